// File: rtl/cdc_handshake_launcher.sv
// Source-domain half of a two-phase (toggle) CDC handshake: launches a held word with a req toggle, completes on synced ack parity.
// Optional watchdog enabled with `define CDC_LAUNCHER_TIMEOUT_EN (adds timeout_o).
module cdc_handshake_launcher #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ACK_SYNC_DEPTH = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  req_o,
  input  logic                  ack_i,
  output logic                  done_o,
  output logic                  ack_err_o
`ifdef CDC_LAUNCHER_TIMEOUT_EN
  ,
  output logic                  timeout_o
`endif
);

  if (ACK_SYNC_DEPTH < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("cdc_handshake_launcher: ACK_SYNC_DEPTH must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic                    req_q, req_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [ACK_SYNC_DEPTH-1:0] sync_q;
  logic                    ack_sync;

`ifdef CDC_LAUNCHER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
`endif

  // Synchronizer runs free of clk_en so ack parity is never missed.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) sync_q <= '0;
    else              sync_q <= {sync_q[ACK_SYNC_DEPTH-2:0], ack_i};
  end

  assign ack_sync = sync_q[ACK_SYNC_DEPTH-1];

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CDC_LAUNCHER_TIMEOUT_EN
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CDC_LAUNCHER_TIMEOUT_EN
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef CDC_LAUNCHER_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
`endif
    if (clk_en) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ack_sync != req_q) err_d = 1'b1;
          if (valid_i && ready_o) begin
            data_d  = data_i;
            req_d   = ~req_q;
            state_d = S_WAIT;
`ifdef CDC_LAUNCHER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        S_WAIT: begin
`ifdef CDC_LAUNCHER_TIMEOUT_EN
          if (!tmo_q) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) tmo_d = 1'b1;
          end
          if (ack_sync == req_q && !tmo_q) begin
`else
          if (ack_sync == req_q) begin
`endif
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign ready_o   = (state_q == S_IDLE) && !err_q;
  assign data_o    = data_q;
  assign req_o     = req_q;
  assign done_o    = done_q;
  assign ack_err_o = err_q;
`ifdef CDC_LAUNCHER_TIMEOUT_EN
  assign timeout_o = tmo_q;
`endif

endmodule

// File: tb/tb_cdc_handshake_launcher.sv
// Directed self-checking bench for cdc_handshake_launcher (default depth 2, 32-bit data).
module tb_cdc_handshake_launcher;
  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        clk_en;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        req_o;
  logic        ack_i;
  logic        done_o;
  logic        ack_err_o;
`ifdef CDC_LAUNCHER_TIMEOUT_EN
  logic        timeout_o;
`endif

  int tests = 0;
  int fails = 0;

  // Destination-side observer state
  logic        mon_en = 1'b0;
  logic        req_prev = 1'b0;
  int          toggles = 0;
  int          dones = 0;
  int          viol = 0;
  logic [31:0] last_cap = '0;
  logic [31:0] cap[$];

  cdc_handshake_launcher #(
    .DATA_WIDTH     (32),
    .ACK_SYNC_DEPTH (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .data_o      (data_o),
    .req_o       (req_o),
    .ack_i       (ack_i),
    .done_o      (done_o),
    .ack_err_o   (ack_err_o)
`ifdef CDC_LAUNCHER_TIMEOUT_EN
    ,
    .timeout_o   (timeout_o)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (req_o != req_prev) begin
        toggles++;
        cap.push_back(data_o);
        last_cap = data_o;
      end
      if (done_o) dones++;
      if (!ready_o && data_o != last_cap) viol++;
    end
    req_prev = req_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    int unsigned dly;
    logic exp_req;
    async_rst_n = 1'b0;
    clk_en = 1'b1;
    valid_i = 1'b0;
    data_i = '0;
    ack_i = 1'b0;
    exp_req = 1'b0;
    tick(); tick();
    async_rst_n = 1'b1;
    repeat (10) tick();

    // Reset state
    check("rst_ready", {31'b0, ready_o}, 32'd1);
    check("rst_req", {31'b0, req_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_done", {31'b0, done_o}, 32'd0);
    check("rst_err", {31'b0, ack_err_o}, 32'd0);

    // Single transfer
    data_i = 32'hDEADBEEF;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    exp_req = 1'b1;
    check("single_req", {31'b0, req_o}, 32'd1);
    check("single_data", data_o, 32'hDEADBEEF);
    check("single_busy", {31'b0, ready_o}, 32'd0);
    repeat (5) tick();
    ack_i = ~ack_i;
    tick();
    check("single_done_t1", {31'b0, done_o}, 32'd0);
    tick();
    check("single_done_t2", {31'b0, done_o}, 32'd0);
    tick();
    check("single_done_t3", {31'b0, done_o}, 32'd1);
    check("single_ready", {31'b0, ready_o}, 32'd1);
    tick();
    check("single_done_end", {31'b0, done_o}, 32'd0);

    // Back-to-back words with random ack delay
    mon_en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      data_i = 32'(k);
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      exp_req = ~exp_req;
      check("b2b_req", {31'b0, req_o}, {31'b0, exp_req});
      dly = $urandom_range(0, 20);
      repeat (dly) tick();
      ack_i = ~ack_i;
      tick(); tick(); tick();
      check("b2b_done", {31'b0, done_o}, 32'd1);
    end
    tick();
    mon_en = 1'b0;
    check("b2b_toggles", 32'(toggles), 32'd3);
    check("b2b_dones", 32'(dones), 32'd3);
    check("b2b_stable", 32'(viol), 32'd0);
    check("b2b_count", 32'(cap.size()), 32'd3);
    if (cap.size() == 3) begin
      check("b2b_cap0", cap[0], 32'h1);
      check("b2b_cap1", cap[1], 32'h2);
      check("b2b_cap2", cap[2], 32'h3);
    end

    // clk_en low across ack toggle
    data_i = 32'hA5;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    exp_req = ~exp_req;
    clk_en = 1'b0;
    ack_i = ~ack_i;
    tick();
    check("en_done_1", {31'b0, done_o}, 32'd0);
    tick();
    check("en_done_2", {31'b0, done_o}, 32'd0);
    check("en_sync", {31'b0, dut.ack_sync}, {31'b0, ack_i});
    tick();
    tick();
    check("en_done_4", {31'b0, done_o}, 32'd0);
    check("en_hold_req", {31'b0, req_o}, {31'b0, exp_req});
    clk_en = 1'b1;
    tick();
    check("en_done_fire", {31'b0, done_o}, 32'd1);
    tick();
    check("en_done_once", {31'b0, done_o}, 32'd0);

    // Spurious ack while idle
    ack_i = ~ack_i;
    tick(); tick(); tick();
    check("spur_err", {31'b0, ack_err_o}, 32'd1);
    check("spur_ready", {31'b0, ready_o}, 32'd0);
    valid_i = 1'b1;
    data_i = 32'h77;
    tick(); tick();
    valid_i = 1'b0;
    check("spur_ignore_req", {31'b0, req_o}, {31'b0, exp_req});
    check("spur_err_sticky", {31'b0, ack_err_o}, 32'd1);
    #2;
    async_rst_n = 1'b0;
    ack_i = 1'b0;
    #1;
    check("spur_rst_err", {31'b0, ack_err_o}, 32'd0);
    check("spur_rst_ready", {31'b0, ready_o}, 32'd1);
    tick();
    async_rst_n = 1'b1;
    exp_req = 1'b0;
    tick(); tick(); tick();
    check("post_rst_err", {31'b0, ack_err_o}, 32'd0);

    // Reset mid-WAIT with ack pending
    data_i = 32'h55;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    check("mid_req", {31'b0, req_o}, 32'd1);
    tick();
    ack_i = 1'b1;
    tick();
    #2;
    async_rst_n = 1'b0;
    ack_i = 1'b0;
    #1;
    check("mid_rst_req", {31'b0, req_o}, 32'd0);
    check("mid_rst_data", data_o, 32'd0);
    check("mid_rst_ready", {31'b0, ready_o}, 32'd1);
    check("mid_rst_done", {31'b0, done_o}, 32'd0);
    tick();
    async_rst_n = 1'b1;
    repeat (4) tick();
    check("mid_post_err", {31'b0, ack_err_o}, 32'd0);
    check("mid_post_done", {31'b0, done_o}, 32'd0);

`ifdef CDC_LAUNCHER_TIMEOUT_EN
    data_i = 32'h99;
    valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    repeat (7) tick();
    check("tmo_early", {31'b0, timeout_o}, 32'd0);
    tick();
    check("tmo_set", {31'b0, timeout_o}, 32'd1);
    check("tmo_stuck", {31'b0, ready_o}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
